// File: rtl/mp_add_seq.sv
// Wide add/subtract sequencer: one DATA_WIDTH-bit add slice is reused NUM_WORDS
// times, least-significant slice first, and the carry is held in a register between slices.
module mp_add_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            sub,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] A,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] B,
    input  logic                            CIN,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_WIDTH*NUM_WORDS-1:0] SUM,
    output logic                            COUT,
    output logic                            OVF
);

    localparam int W     = DATA_WIDTH * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_bx;
    logic [W-1:0]          r_sum;
    logic                  r_carry;
    logic                  r_cout;
    logic                  r_ovf;
    logic [IDX_W-1:0]      r_idx;
    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_a_sl;
    logic [DATA_WIDTH-1:0] w_b_sl;
    logic [DATA_WIDTH-1:0] w_s;
    logic                  w_c;
    logic                  w_c_msb;

    // Slice mux and the shared ripple adder
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_sl = r_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_b_sl = r_bx[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        {w_c, w_s} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{DATA_WIDTH{1'b0}}, r_carry};
        // Carry into the MSB recovered from the MSB sum bit and its two operand bits
        w_c_msb = w_s[DATA_WIDTH-1] ^ w_a_sl[DATA_WIDTH-1] ^ w_b_sl[DATA_WIDTH-1];
    end

    assign w_last   = (r_idx == IDX_W'(NUM_WORDS - 1));
    assign w_accept = start && (r_state != S_RUN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, per-slice writeback and final flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_bx    <= sub ? ~B : B;
            r_carry <= sub ? 1'b1 : CIN;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_sum[i*DATA_WIDTH +: DATA_WIDTH] <= w_s;
                end
            end
            r_carry <= w_c;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_cout <= w_c;
                r_ovf  <= w_c_msb ^ w_c;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign SUM  = r_sum;
    assign COUT = r_cout;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: a whole-word arithmetic model checked every cycle,
// plus directed operations with hand-computed results and timing.
module tb_mp_add_seq;

    localparam int DW = 8;
    localparam int NW = 4;
    localparam int W  = DW * NW;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         CIN = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, COUT, OVF;
    logic [W-1:0] SUM;

    always #5 clk = ~clk;

    mp_add_seq #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .CIN(CIN),
        .busy(busy), .done(done), .SUM(SUM), .COUT(COUT), .OVF(OVF)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: whole-word arithmetic, result published N edges after acceptance
    int           m_left = 0;
    bit           m_done = 1'b0;
    bit           m_init = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] p_sum, p_bx;
    logic         p_cout, p_ovf;
    logic [W:0]   p_full;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
            m_init = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
                end
            end else if (start) begin
                p_bx   = sub ? ~B : B;
                p_full = {1'b0, A} + {1'b0, p_bx} + (W+1)'(sub ? 1'b1 : CIN);
                p_sum  = p_full[W-1:0];
                p_cout = p_full[W];
                p_ovf  = (A[W-1] == p_bx[W-1]) && (p_sum[W-1] != A[W-1]);
                m_left = NW;
                m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            if (m_left == 0) begin
                chk("sum", SUM, m_sum);
                chk("cout", COUT, m_cout);
                chk("ovf", OVF, m_ovf);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sb, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string name);
        int k;
        @(negedge clk);
        A = a; B = b; CIN = cin; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_latency"}, k, 5);
        chk({name, "_sum"}, SUM, es);
        chk({name, "_cout"}, COUT, ec);
        chk({name, "_ovf"}, OVF, eo);
    endtask

    initial begin
        int pulses, cnt, t1, t2;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_cout", COUT, 0);
        chk("rst_ovf", OVF, 0);
        rst = 1'b0;

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "add_wrap");
        run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "sub_ovf");
        run_op(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, "add_cin_ovf");
        run_op(32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000D, 1'b1, 1'b0, "sub_cin_ignored");

        // start pulses on RUN cycles 2 and 3 must be ignored
        @(negedge clk);
        A = 32'h00001000; B = 32'h00000234; CIN = 1'b0; sub = 1'b0; start = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 2) begin A = 32'hFFFF0000; B = 32'h00012345; start = 1'b1; end
            if (c == 4) start = 1'b0;
            if (done) begin
                pulses++;
                chk("busy_start_sum", SUM, 32'h00001234);
                chk("busy_start_at", c, 5);
            end
        end
        chk("busy_start_pulses", pulses, 1);

        // back-to-back: start held through DONE with new operands
        @(negedge clk);
        A = 32'h00000010; B = 32'h00000020; CIN = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 32'h01020304; B = 32'h10203040;
        cnt = 1; t1 = -1; t2 = -1;
        while (t2 < 0 && cnt < 30) begin
            @(negedge clk);
            cnt++;
            if (t1 >= 0 && cnt == t1 + 1) start = 1'b0;
            if (done) begin
                if (t1 < 0) begin
                    t1 = cnt;
                    chk("b2b_first_sum", SUM, 32'h00000030);
                end else begin
                    t2 = cnt;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_at", t1, 5);
        chk("b2b_spacing", t2 - t1, 5);
        chk("b2b_second_sum", SUM, 32'h11223344);

        // reset asserted on the third RUN cycle aborts the operation
        @(negedge clk);
        A = 32'h12345678; B = 32'h11111111; CIN = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", SUM, 0);
        chk("midrst_cout", COUT, 0);
        chk("midrst_ovf", OVF, 0);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, "post_rst");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
